// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - fetch/data arbiter sharing one variable-latency memory port
//
// Purpose:
//   Grants a single memory port to either instruction fetch or the data stage,
//   one outstanding operation at a time. Data has priority, except that after
//   STARVE_MAX consecutive data grants with a fetch pending, the next grant goes
//   to fetch. Fetch responses made stale by a taken jump are dropped.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   if_req/if_addr/if_flush  fetch request level, PC, jump-taken flush
//   if_instr/imem_ready      fetched instruction and its one-cycle valid pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_be             data access request level and its fields
//   d_rdata/d_done           load data and the one-cycle completion pulse
//   dstall                   d_req & ~d_done, combinational pipeline stall
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be         registered memory request, held until mem_ack
//   mem_rdata/mem_ack        memory read data and one-cycle completion pulse

module imem_dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_instr,
    output logic                imem_ready,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                dstall,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DACC   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             flush_pend;

    logic             grant_d;
    logic             grant_i;
    logic             fetch_ack;
    logic             data_ack;
    logic             fetch_stale;

    // ------------------------------------------------------------------
    // Next-state and grant decision. Grants are only made from IDLE, so a
    // completed transaction is always followed by at least one IDLE cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        unique case (state)
            IDLE: begin
                // Data wins unless fetch is waiting and has already been
                // passed over STARVE_MAX times in a row.
                if (d_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
                    grant_d   = 1'b1;
                    state_nxt = DACC;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = IFETCH;
                end
            end
            IFETCH, DACC: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fetch_ack   = (state == IFETCH) && mem_ack;
    assign data_ack    = (state == DACC) && mem_ack;
    // A flush arriving in the same cycle as the ack also kills the response.
    assign fetch_stale = flush_pend || if_flush;

    // Stall is combinational so the pipeline advances in the d_done cycle.
    assign dstall = d_req & ~d_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Anti-starvation counter: counts data grants that bypassed a pending
    // fetch. Any cycle without a fetch request resets the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!if_req) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pending-flush flag: remembers a jump seen while the fetch is in flight
    // so its eventual response is discarded. Cleared when that ack arrives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pend <= 1'b0;
        end else if (state == IFETCH) begin
            if (mem_ack) begin
                flush_pend <= 1'b0;
            end else if (if_flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory request registers: captured on grant, held until mem_ack.
    // Later changes on if_addr/d_* cannot disturb the in-flight operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
        end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= {BE_W{1'b1}};
        end else if (fetch_ack || data_ack) begin
            mem_req   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Fetch response path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_ready <= 1'b0;
            if_instr   <= '0;
        end else begin
            imem_ready <= 1'b0;
            if (fetch_ack && !fetch_stale) begin
                imem_ready <= 1'b1;
                if_instr   <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data response path: stores complete without touching d_rdata.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_done  <= 1'b0;
            d_rdata <= '0;
        end else begin
            d_done <= 1'b0;
            if (data_ack) begin
                d_done <= 1'b1;
                if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
